// File: rtl/rvv_lsu_responder_pkg.sv
// Shared types for the RVV<->LSU uop responder: queued command/uop records,
// responder FSM states and the masked-load byte merge.
package rvv_lsu_responder_pkg;

  localparam int unsigned VLEN_BYTES = 16;
  localparam int unsigned LSU_AW     = 32;

  typedef struct packed {
    logic [LSU_AW-1:0] addr;
    logic              store;
    logic [4:0]        vd;
    logic              last;
  } lsu_cmd_t;

  typedef struct packed {
    logic                      idx_valid;
    logic                      vreg_valid;
    logic [VLEN_BYTES*8-1:0]   vreg_data;
    logic                      v0_valid;
    logic [VLEN_BYTES-1:0]     v0_data;
  } lsu_uop_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_WB
  } lsu_resp_state_e;

  // Active bytes take the memory data; inactive bytes keep the old destination.
  function automatic logic [VLEN_BYTES*8-1:0] merge_load(
    input logic [VLEN_BYTES*8-1:0] rsp,
    input logic [VLEN_BYTES*8-1:0] old,
    input logic [VLEN_BYTES-1:0]   strb
  );
    logic [VLEN_BYTES*8-1:0] m;
    for (int unsigned b = 0; b < VLEN_BYTES; b++) begin
      m[b*8 +: 8] = strb[b] ? rsp[b*8 +: 8] : old[b*8 +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/rvv_lsu_fifo.sv
// Parameterized synchronous FIFO; pointers carry one extra wrap bit so the
// occupancy is simply wptr - rptr.
module rvv_lsu_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  T     din,
  output logic full,
  input  logic pop,
  output T     dout,
  output logic empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  T            mem [DEPTH];
  logic [PW:0] wptr;
  logic [PW:0] rptr;
  logic [PW:0] count;
  logic        do_push;
  logic        do_pop;

  assign count   = wptr - rptr;
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr[PW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/rvv_lsu_responder.sv
// LSU-lane endpoint of the RVV uop interface: pairs a vector uop with a scalar
// command, issues one 128-bit memory beat and returns load data or a store "last".
module rvv_lsu_responder
  import rvv_lsu_responder_pkg::*;
#(
  parameter int unsigned UOP_DEPTH = 4,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned AW        = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          uop_valid_i,
  output logic          uop_ready_o,
  input  logic          uop_idx_valid_i,
  input  logic          uop_vreg_valid_i,
  input  logic [4:0]    uop_vreg_addr_i,
  input  logic [127:0]  uop_vreg_data_i,
  input  logic          uop_v0_valid_i,
  input  logic [15:0]   uop_v0_data_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic          cmd_store_i,
  input  logic [4:0]    cmd_vd_i,
  input  logic          cmd_last_i,
  output logic          mem_req_valid_o,
  input  logic          mem_req_ready_i,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [127:0]  mem_wdata_o,
  output logic [15:0]   mem_wstrb_o,
  input  logic          mem_rsp_valid_i,
  input  logic [127:0]  mem_rsp_data_i,
  output logic          wb_valid_o,
  output logic [4:0]    wb_addr_o,
  output logic [127:0]  wb_data_o,
  output logic          wb_last_o,
  input  logic          wb_ready_i,
  output logic          err_o
);

  lsu_uop_t        uop_in, uop_head, uop_q;
  lsu_cmd_t        cmd_in, cmd_head, cmd_q;
  lsu_resp_state_e state, state_nxt;
  logic            uop_full, uop_empty, uop_push;
  logic            cmd_full, cmd_empty, cmd_push;
  logic            pair;
  logic [15:0]     strb_q;
  logic [127:0]    merged_q;
  logic            err_q;
  logic            unused_bits;

  assign uop_ready_o = !uop_full;
  assign cmd_ready_o = !cmd_full;
  assign uop_push    = uop_valid_i && uop_ready_o;
  assign cmd_push    = cmd_valid_i && cmd_ready_o;
  assign pair        = (state == ST_IDLE) && !uop_empty && !cmd_empty;
  assign strb_q      = uop_q.v0_valid ? uop_q.v0_data : '1;
  assign err_o       = err_q;
  assign unused_bits = ^{uop_vreg_addr_i, uop_q.idx_valid, cmd_q.addr};

  always_comb begin
    uop_in            = '0;
    uop_in.idx_valid  = uop_idx_valid_i;
    uop_in.vreg_valid = uop_vreg_valid_i;
    uop_in.vreg_data  = uop_vreg_data_i;
    uop_in.v0_valid   = uop_v0_valid_i;
    uop_in.v0_data    = uop_v0_data_i;
    cmd_in            = '0;
    cmd_in.addr[AW-1:0] = cmd_addr_i;
    cmd_in.store      = cmd_store_i;
    cmd_in.vd         = cmd_vd_i;
    cmd_in.last       = cmd_last_i;
  end

  rvv_lsu_fifo #(.T(lsu_uop_t), .DEPTH(UOP_DEPTH)) u_uop_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (uop_push),
    .din   (uop_in),
    .full  (uop_full),
    .pop   (pair),
    .dout  (uop_head),
    .empty (uop_empty)
  );

  rvv_lsu_fifo #(.T(lsu_cmd_t), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (cmd_push),
    .din   (cmd_in),
    .full  (cmd_full),
    .pop   (pair),
    .dout  (cmd_head),
    .empty (cmd_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_q    <= '0;
      uop_q    <= '0;
      merged_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (pair) begin
        cmd_q <= cmd_head;
        uop_q <= uop_head;
      end
      if (state == ST_WAIT && mem_rsp_valid_i && !cmd_q.store) begin
        merged_q <= merge_load(mem_rsp_data_i,
                               uop_q.vreg_valid ? uop_q.vreg_data : mem_rsp_data_i,
                               strb_q);
      end
      if (uop_push && uop_idx_valid_i) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt       = state;
    mem_req_valid_o = 1'b0;
    mem_addr_o      = '0;
    mem_we_o        = 1'b0;
    mem_wdata_o     = '0;
    mem_wstrb_o     = '0;
    wb_valid_o      = 1'b0;
    wb_addr_o       = '0;
    wb_data_o       = '0;
    wb_last_o       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pair) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = cmd_q.addr[AW-1:0];
        mem_we_o        = cmd_q.store;
        if (cmd_q.store) begin
          mem_wdata_o = uop_q.vreg_data;
          mem_wstrb_o = strb_q;
        end else begin
          mem_wstrb_o = '1;
        end
        if (mem_req_ready_i) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rsp_valid_i) begin
          if (!cmd_q.store || cmd_q.last) state_nxt = ST_WB;
          else                            state_nxt = ST_IDLE;
        end
      end
      ST_WB: begin
        wb_valid_o = 1'b1;
        if (cmd_q.store) begin
          wb_last_o = 1'b1;
        end else begin
          wb_addr_o = cmd_q.vd;
          wb_data_o = merged_q;
        end
        if (wb_ready_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rvv_lsu_responder.sv
// Directed bench for rvv_lsu_responder with a queue-based transaction model,
// a small memory model and per-cycle checking of request/writeback beats.
module tb_rvv_lsu_responder;

  logic          clk = 1'b0;
  logic          rstn;
  logic          uop_valid_i, uop_ready_o, uop_idx_valid_i, uop_vreg_valid_i;
  logic [4:0]    uop_vreg_addr_i;
  logic [127:0]  uop_vreg_data_i;
  logic          uop_v0_valid_i;
  logic [15:0]   uop_v0_data_i;
  logic          cmd_valid_i, cmd_ready_o;
  logic [31:0]   cmd_addr_i;
  logic          cmd_store_i;
  logic [4:0]    cmd_vd_i;
  logic          cmd_last_i;
  logic          mem_req_valid_o, mem_req_ready_i;
  logic [31:0]   mem_addr_o;
  logic          mem_we_o;
  logic [127:0]  mem_wdata_o;
  logic [15:0]   mem_wstrb_o;
  logic          mem_rsp_valid_i;
  logic [127:0]  mem_rsp_data_i;
  logic          wb_valid_o;
  logic [4:0]    wb_addr_o;
  logic [127:0]  wb_data_o;
  logic          wb_last_o;
  logic          wb_ready_i;
  logic          err_o;

  always #5 clk = ~clk;

  rvv_lsu_responder #(.UOP_DEPTH(4), .CMD_DEPTH(4), .AW(32)) dut (
    .clk(clk), .rstn(rstn),
    .uop_valid_i(uop_valid_i), .uop_ready_o(uop_ready_o),
    .uop_idx_valid_i(uop_idx_valid_i), .uop_vreg_valid_i(uop_vreg_valid_i),
    .uop_vreg_addr_i(uop_vreg_addr_i), .uop_vreg_data_i(uop_vreg_data_i),
    .uop_v0_valid_i(uop_v0_valid_i), .uop_v0_data_i(uop_v0_data_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_store_i(cmd_store_i),
    .cmd_vd_i(cmd_vd_i), .cmd_last_i(cmd_last_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .wb_last_o(wb_last_o), .wb_ready_i(wb_ready_i), .err_o(err_o)
  );

  typedef struct { logic [31:0] addr; logic store; logic [4:0] vd; logic last; } mcmd_t;
  typedef struct { logic idx; logic vv; logic [127:0] vd; logic v0v; logic [15:0] v0; } muop_t;
  typedef struct { mcmd_t c; muop_t u; } mpair_t;
  typedef struct { logic [4:0] addr; logic [127:0] data; logic last; } mwb_t;

  mcmd_t  cq[$];
  muop_t  uq[$];
  mpair_t infl[$];
  mwb_t   wq[$];

  int n_vec = 0, n_miss = 0;
  int wb_beats = 0, last_beats = 0, store_wr = 0, req_hs = 0;
  logic [15:0]  last_store_strb = '0;
  logic         err_exp = 1'b0;
  logic         mem_rdy_ctl = 1'b1, wb_rdy_ctl = 1'b1, rsp_hold = 1'b0;
  logic         pend = 1'b0, pwe;
  logic [31:0]  paddr;
  logic [127:0] pwdata;
  logic [15:0]  pstrb;
  logic [127:0] memarr [logic [31:0]];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rd(input logic [31:0] a);
    return memarr.exists(a) ? memarr[a] : '0;
  endfunction

  // Memory and ready drivers: one response the cycle after each accepted request.
  always @(posedge clk) begin
    logic [127:0] line;
    #1;
    mem_req_ready_i = mem_rdy_ctl;
    wb_ready_i      = wb_rdy_ctl;
    if (!rstn) begin
      pend = 1'b0;
      mem_rsp_valid_i = 1'b0;
      mem_rsp_data_i  = '0;
    end else if (pend && !rsp_hold) begin
      mem_rsp_valid_i = 1'b1;
      if (pwe) begin
        line = rd(paddr);
        for (int b = 0; b < 16; b++) if (pstrb[b]) line[b*8 +: 8] = pwdata[b*8 +: 8];
        memarr[paddr] = line;
        mem_rsp_data_i = '0;
      end else begin
        mem_rsp_data_i = rd(paddr);
      end
      pend = 1'b0;
    end else begin
      mem_rsp_valid_i = 1'b0;
    end
  end

  logic         prev_req_stall = 1'b0, prev_wb_stall = 1'b0;
  logic [177:0] prev_req;
  logic [134:0] prev_wb;

  always @(negedge clk) begin
    mcmd_t c; muop_t u; mpair_t p; mwb_t w;
    logic [15:0] strb; logic [127:0] m, old;
    if (!rstn) begin
      cq.delete(); uq.delete(); infl.delete(); wq.delete();
      err_exp = 1'b0; prev_req_stall = 1'b0; prev_wb_stall = 1'b0;
    end else begin
      chk("err_o", 256'(err_o), 256'(err_exp));
      if (mem_rsp_valid_i) begin
        chk("rsp_only_in_wait", 256'(infl.size()), 256'(1));
        if (infl.size() > 0) begin
          p = infl.pop_front();
          strb = p.u.v0v ? p.u.v0 : 16'hFFFF;
          if (!p.c.store) begin
            for (int b = 0; b < 16; b++) begin
              old = p.u.vv ? p.u.vd : mem_rsp_data_i;
              m[b*8 +: 8] = strb[b] ? mem_rsp_data_i[b*8 +: 8] : old[b*8 +: 8];
            end
            wq.push_back(mwb_t'{p.c.vd, m, 1'b0});
          end else if (p.c.last) begin
            wq.push_back(mwb_t'{5'd0, 128'd0, 1'b1});
          end
        end
      end
      if (prev_req_stall)
        chk("req_hold", 256'({mem_req_valid_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_wstrb_o}), 256'(prev_req));
      if (mem_req_valid_o && mem_req_ready_i) begin
        req_hs++;
        chk("req_has_pair", 256'(uq.size() > 0 && cq.size() > 0), 256'(1));
        if (uq.size() > 0 && cq.size() > 0) begin
          c = cq.pop_front();
          u = uq.pop_front();
          strb = u.v0v ? u.v0 : 16'hFFFF;
          chk("req_addr", 256'(mem_addr_o), 256'(c.addr));
          chk("req_we", 256'(mem_we_o), 256'(c.store));
          chk("req_wstrb", 256'(mem_wstrb_o), 256'(c.store ? strb : 16'hFFFF));
          if (c.store) begin
            chk("req_wdata", 256'(mem_wdata_o), 256'(u.vd));
            store_wr++;
            last_store_strb = mem_wstrb_o;
          end
          infl.push_back(mpair_t'{c, u});
        end
        pend = 1'b1; paddr = mem_addr_o; pwe = mem_we_o; pwdata = mem_wdata_o; pstrb = mem_wstrb_o;
      end
      prev_req_stall = mem_req_valid_o && !mem_req_ready_i;
      prev_req = {mem_req_valid_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_wstrb_o};
      if (prev_wb_stall)
        chk("wb_hold", 256'({wb_valid_o, wb_addr_o, wb_data_o, wb_last_o}), 256'(prev_wb));
      if (wb_valid_o && wb_ready_i) begin
        chk("wb_expected", 256'(wq.size() > 0), 256'(1));
        if (wq.size() > 0) begin
          w = wq.pop_front();
          chk("wb_addr", 256'(wb_addr_o), 256'(w.addr));
          chk("wb_data", 256'(wb_data_o), 256'(w.data));
          chk("wb_last", 256'(wb_last_o), 256'(w.last));
        end
        wb_beats++;
        if (wb_last_o) last_beats++;
      end
      prev_wb_stall = wb_valid_o && !wb_ready_i;
      prev_wb = {wb_valid_o, wb_addr_o, wb_data_o, wb_last_o};
      if (uop_valid_i && uop_ready_o) begin
        uq.push_back(muop_t'{uop_idx_valid_i, uop_vreg_valid_i, uop_vreg_data_i, uop_v0_valid_i, uop_v0_data_i});
        if (uop_idx_valid_i) err_exp = 1'b1;
      end
      if (cmd_valid_i && cmd_ready_o)
        cq.push_back(mcmd_t'{cmd_addr_i, cmd_store_i, cmd_vd_i, cmd_last_i});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_uop(input logic idx, input logic vv, input logic [127:0] vd,
                          input logic v0v, input logic [15:0] v0);
    int t = 0;
    uop_valid_i = 1'b1; uop_idx_valid_i = idx; uop_vreg_valid_i = vv;
    uop_vreg_data_i = vd; uop_v0_valid_i = v0v; uop_v0_data_i = v0;
    while (!uop_ready_o && t < 100) begin tick(1); t++; end
    chk("uop_accept_wait", 256'(t < 100), 256'(1));
    tick(1);
    uop_valid_i = 1'b0; uop_idx_valid_i = 1'b0;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic st, input logic [4:0] vd, input logic last);
    int t = 0;
    cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_store_i = st; cmd_vd_i = vd; cmd_last_i = last;
    while (!cmd_ready_o && t < 100) begin tick(1); t++; end
    chk("cmd_accept_wait", 256'(t < 100), 256'(1));
    tick(1);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_wb(input int target);
    int t = 0;
    while (wb_beats < target && t < 300) begin tick(1); t++; end
    chk("wb_count", 256'(wb_beats), 256'(target));
  endtask

  task automatic wait_wb_valid(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!wb_valid_o && lat < 50);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, base_wb, base_last, base_st, base_req, t;
    rstn = 1'b1;
    uop_valid_i = 0; uop_idx_valid_i = 0; uop_vreg_valid_i = 0; uop_vreg_addr_i = '0;
    uop_vreg_data_i = '0; uop_v0_valid_i = 0; uop_v0_data_i = '0;
    cmd_valid_i = 0; cmd_addr_i = '0; cmd_store_i = 0; cmd_vd_i = '0; cmd_last_i = 0;
    mem_req_ready_i = 1; mem_rsp_valid_i = 0; mem_rsp_data_i = '0; wb_ready_i = 1;
    #2 rstn = 1'b0;
    tick(3);
    chk("rst_wb_valid", 256'(wb_valid_o), 256'(0));
    chk("rst_wb_last", 256'(wb_last_o), 256'(0));
    chk("rst_req_valid", 256'(mem_req_valid_o), 256'(0));
    chk("rst_mem_wstrb", 256'(mem_wstrb_o), 256'(0));
    chk("rst_err", 256'(err_o), 256'(0));
    chk("rst_uop_ready", 256'(uop_ready_o), 256'(1));
    chk("rst_cmd_ready", 256'(cmd_ready_o), 256'(1));
    rstn = 1'b1;
    tick(2);

    // Unmasked load, 4-cycle pairing-to-writeback latency
    memarr[32'h100] = 128'h00112233445566778899AABBCCDDEEFF;
    fork
      send_uop(1'b0, 1'b0, '0, 1'b0, '0);
      send_cmd(32'h100, 1'b0, 5'd3, 1'b0);
    join
    wait_wb_valid(lat);
    chk("load_latency", 256'(lat), 256'(4));
    chk("load_wb_addr", 256'(wb_addr_o), 256'(3));
    chk("load_wb_data", 256'(wb_data_o), 256'(128'h00112233445566778899AABBCCDDEEFF));
    chk("load_wb_last", 256'(wb_last_o), 256'(0));
    wait_wb(1);

    // Masked load merging old vd
    memarr[32'h200] = {16{8'h55}};
    fork
      send_uop(1'b0, 1'b1, {16{8'hAA}}, 1'b1, 16'h00FF);
      send_cmd(32'h200, 1'b0, 5'd7, 1'b0);
    join
    wait_wb_valid(lat);
    chk("mload_wb_data", 256'(wb_data_o), 256'(128'hAAAAAAAAAAAAAAAA5555555555555555));
    wait_wb(2);

    // Two-uop store chain, last on the second
    base_wb = wb_beats; base_last = last_beats; base_st = store_wr;
    fork
      begin
        send_uop(1'b0, 1'b1, {16{8'h11}}, 1'b1, 16'hF0F0);
        send_uop(1'b0, 1'b1, {16{8'h22}}, 1'b1, 16'hF0F0);
      end
      begin
        send_cmd(32'h300, 1'b1, 5'd0, 1'b0);
        send_cmd(32'h310, 1'b1, 5'd0, 1'b1);
      end
    join
    wait_wb(base_wb + 1);
    tick(10);
    chk("store_writes", 256'(store_wr - base_st), 256'(2));
    chk("store_wstrb", 256'(last_store_strb), 256'(16'hF0F0));
    chk("store_last_beats", 256'(last_beats - base_last), 256'(1));
    chk("store_wb_beats", 256'(wb_beats - base_wb), 256'(1));
    chk("store_mem0", 256'(rd(32'h300)), 256'(128'h11111111000000001111111100000000));

    // Backpressure on memory and writeback; uop FIFO fill
    mem_rdy_ctl = 1'b0; wb_rdy_ctl = 1'b0;
    tick(1);
    base_wb = wb_beats;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] bv;
      bv = 8'(8'h10 + i);
      send_uop(1'b0, 1'b1, {16{bv}}, 1'b1, 16'h0F0F);
    end
    uop_valid_i = 1'b1;
    #1 chk("fifth_uop_ready", 256'(uop_ready_o), 256'(0));
    uop_valid_i = 1'b0;
    memarr[32'h400] = {8{16'hBEEF}};
    memarr[32'h410] = {4{32'h01234567}};
    send_cmd(32'h400, 1'b0, 5'd1, 1'b0);
    t = 0;
    while (!mem_req_valid_o && t < 50) begin tick(1); t++; end
    chk("bp_req_seen", 256'(mem_req_valid_o), 256'(1));
    tick(5);
    mem_rdy_ctl = 1'b1;
    t = 0;
    while (!wb_valid_o && t < 50) begin tick(1); t++; end
    chk("bp_wb_seen", 256'(wb_valid_o), 256'(1));
    chk("uop_ready_after_pop", 256'(uop_ready_o), 256'(1));
    tick(3);
    wb_rdy_ctl = 1'b1;
    send_cmd(32'h410, 1'b0, 5'd2, 1'b0);
    send_cmd(32'h420, 1'b0, 5'd4, 1'b0);
    send_cmd(32'h430, 1'b0, 5'd6, 1'b0);
    wait_wb(base_wb + 4);

    // Command arrives well before its uop; indexed uop flags err_o
    base_req = req_hs; base_wb = wb_beats;
    memarr[32'h500] = 128'hCAFE0000CAFE1111CAFE2222CAFE3333;
    send_cmd(32'h500, 1'b0, 5'd9, 1'b0);
    tick(10);
    chk("skew_no_req", 256'(req_hs), 256'(base_req));
    chk("err_before_idx", 256'(err_o), 256'(0));
    send_uop(1'b1, 1'b0, '0, 1'b0, '0);
    wait_wb(base_wb + 1);
    chk("skew_req_after_uop", 256'(req_hs), 256'(base_req + 1));
    chk("err_after_idx", 256'(err_o), 256'(1));

    // Reset while waiting on the memory response
    rsp_hold = 1'b1;
    base_req = req_hs; base_wb = wb_beats;
    fork
      send_uop(1'b0, 1'b0, '0, 1'b0, '0);
      send_cmd(32'h600, 1'b0, 5'd10, 1'b0);
    join
    send_cmd(32'h700, 1'b1, 5'd0, 1'b1);
    t = 0;
    while (req_hs == base_req && t < 50) begin tick(1); t++; end
    chk("rst_wait_req_seen", 256'(req_hs), 256'(base_req + 1));
    #2 rstn = 1'b0;
    #1;
    chk("rstw_wb_valid", 256'(wb_valid_o), 256'(0));
    chk("rstw_req_valid", 256'(mem_req_valid_o), 256'(0));
    chk("rstw_err", 256'(err_o), 256'(0));
    chk("rstw_cmd_ready", 256'(cmd_ready_o), 256'(1));
    tick(2);
    rstn = 1'b1;
    rsp_hold = 1'b0;
    send_uop(1'b0, 1'b1, {16{8'h77}}, 1'b0, '0);
    tick(10);
    chk("post_rst_no_req", 256'(req_hs), 256'(base_req + 1));
    chk("post_rst_no_wb", 256'(wb_beats), 256'(base_wb));
    send_cmd(32'h800, 1'b1, 5'd0, 1'b1);
    wait_wb(base_wb + 1);
    chk("post_rst_store_mem", 256'(rd(32'h800)), 256'({16{8'h77}}));

    tick(5);
    chk("model_wb_drained", 256'(wq.size()), 256'(0));
    chk("model_inflight_drained", 256'(infl.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rvv_lsu_responder.md
Name: rvv_lsu_responder

Overview:
- LSU-side endpoint of the RVV↔LSU uop interface, one instance per LSU lane (`NUM_LSU` instances).
- Pairs each RVV LSU uop (store data, v0 mask, old-vd data) with a scalar-side memory command and performs one 128-bit memory beat per uop.
- Returns load data, or a store-completion "last" beat, on the LSU→RVV writeback channel.
- Sits in the scalar LSU between the vector backend, the scalar command issue and the data-memory port.

Parameters:
- UOP_DEPTH, 4, entries in the RVV uop FIFO (power of 2, ≥2)
- CMD_DEPTH, 4, entries in the scalar command FIFO (power of 2, ≥2)
- AW, 32, memory byte-address width

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- uop_valid_i  in  1  uop_lsu_valid_rvv2lsu lane bit
- uop_ready_o  out  1  uop_lsu_ready_lsu2rvv lane bit
- uop_idx_valid_i  in  1  indexed-access flag (unsupported)
- uop_vreg_valid_i  in  1  vregfile_read_valid
- uop_vreg_addr_i  in  5  vregfile_read_addr (unused internally)
- uop_vreg_data_i  in  128  store data (store) / old vd (load)
- uop_v0_valid_i  in  1  uop is masked
- uop_v0_data_i  in  16  byte-enable mask
- cmd_valid_i  in  1  scalar LSU command valid
- cmd_ready_o  out  1  command accept
- cmd_addr_i  in  AW  16-byte-aligned base address
- cmd_store_i  in  1  1 = store, 0 = load
- cmd_vd_i  in  5  load destination register
- cmd_last_i  in  1  last uop of the instruction
- mem_req_valid_o  out  1  memory request
- mem_req_ready_i  in  1  memory accept
- mem_addr_o  out  AW  request address
- mem_we_o  out  1  write enable
- mem_wdata_o  out  128  write data
- mem_wstrb_o  out  16  byte strobes
- mem_rsp_valid_i  in  1  response; one per request, rdata ignored for writes
- mem_rsp_data_i  in  128  read data
- wb_valid_o  out  1  uop_lsu_valid_lsu2rvv
- wb_addr_o  out  5  uop_lsu_addr_lsu2rvv
- wb_data_o  out  128  uop_lsu_wdata_lsu2rvv
- wb_last_o  out  1  uop_lsu_last_lsu2rvv
- wb_ready_i  in  1  uop_lsu_ready_rvv2lsu
- err_o  out  1  sticky: indexed uop received

Behaviour:
- Reset values:
  - all `*_valid_o`, `wb_*`, `mem_*` and `err_o` are 0.
  - FIFOs empty; FSM in IDLE.
  - `uop_ready_o` and `cmd_ready_o` are 1 (FIFOs not full).
- Ready signals:
  - `uop_ready_o` = uop FIFO not full.
  - `cmd_ready_o` = cmd FIFO not full.
  - A push and a pop of the same FIFO in one cycle are both honoured; the full flag does not block the push when a pop happens that cycle.
- Indexed uops:
  - A uop with `uop_idx_valid_i` is still accepted and processed as unit-stride.
  - Its acceptance sets `err_o`, which stays set until reset.
- Mask: `strb` = `uop_v0_valid` ? `v0_data` : 16'hFFFF.
- FSM: IDLE → REQ → WAIT → WB → IDLE.
  - IDLE: when both FIFO heads are valid, latch the pair and pop both in the same cycle; go to REQ next cycle.
  - REQ: `mem_req_valid_o` = 1, `mem_addr_o` = cmd addr, `mem_we_o` = store.
    - Store: `wdata` = vreg_data, `wstrb` = strb.
    - Load: `wstrb` = 16'hFFFF.
    - Hold all fields stable until `mem_req_ready_i`; then go to WAIT.
  - WAIT: on `mem_rsp_valid_i`:
    - Load: form merged data (byte b = strb[b] ? rsp[b] : old-vd[b]; old vd = vreg_data if vreg_valid else rsp[b]); go to WB.
    - Store with last = 1: go to WB.
    - Store with last = 0: go to IDLE.
  - WB:
    - Load: `wb_valid_o` = 1, `wb_addr_o` = vd, `wb_data_o` = merged, `wb_last_o` = 0.
    - Store: `wb_valid_o` = 1, `wb_last_o` = 1, `wb_addr_o` = 0, `wb_data_o` = 0.
    - Hold stable until `wb_ready_i`; then go to IDLE.
- Loads never assert `wb_last_o`.
- Latency with an immediately-ready memory returning its response the next cycle: pairing → wb_valid is 4 cycles (IDLE, REQ, WAIT, WB).
- One transaction in flight; no back-to-back overlap.
- A `mem_rsp_valid_i` outside WAIT is ignored. This is a protocol violation, and the bench asserts it never occurs.
- Pointers are log2(depth) bits with one extra wrap bit; count = wptr − rptr.
- Asynchronous reset mid-transaction aborts it: no writeback is produced and both FIFOs are flushed.

Decomposition:
- Shared package additions:
  - `lsu_cmd_t` {addr, store, vd, last}.
  - `lsu_uop_t` {idx_valid, vreg_valid, vreg_data, v0_valid, v0_data}.
  - FSM state enum `lsu_resp_state_e`.
  - `VLEN_BYTES` = 16.
- One natural sub-module: `rvv_lsu_fifo`, a parameterized sync FIFO (type T, DEPTH), instantiated twice.

Test Plan:
- Unmasked load: cmd{addr=0x100, load, vd=3}, uop{v0_valid=0}; memory returns 0x00112233..FF → one wb beat with addr=3, that data, last=0, at 4 cycles.
- Masked load: v0=16'h00FF, vreg_data=all 0xAA, rsp=all 0x55 → wb data upper 8 bytes 0xAA, lower 8 bytes 0x55.
- Store chain: 2 uops, last on the second, v0_valid=1, mask=16'hF0F0 → two writes with wstrb=F0F0, then exactly one wb beat with last=1.
- Backpressure: mem_req_ready low 5 cycles and wb_ready low 3 cycles → all request and wb fields stable throughout; FIFOs fill to depth 4, the fifth uop sees uop_ready=0.
- Arrival skew: cmd arrives 10 cycles before its uop → no memory request until the uop arrives; idx_valid uop → err_o=1 and still serviced.
- Reset asserted in WAIT → wb_valid and mem_req_valid go to 0 immediately, FIFOs empty, no late wb beat after release.
